// File: rtl/rs_issue_select_pkg.sv
// Shared sizing for the RS select stage: entry count, index width and index type.
package rs_issue_select_pkg;
  localparam int RS_ENTRIES = 16;
  localparam int IDX_W      = $clog2(RS_ENTRIES);

  typedef logic [IDX_W-1:0] rs_idx_t;
endpackage

// File: rtl/rs_issue_select_if.sv
// Select-stage bundle: dispatch alloc, wakeup request/grant, FU issue handshake and free return.
interface rs_issue_select_if #(
  parameter int RS_ENTRIES = rs_issue_select_pkg::RS_ENTRIES
);
  localparam int IDX_W = $clog2(RS_ENTRIES);

  logic                  flush;
  logic                  alloc_en;
  logic [IDX_W-1:0]      alloc_index;
  logic [RS_ENTRIES-1:0] request_vector;
  logic                  grant_en;
  logic [IDX_W-1:0]      grant_index;
  logic                  issue_valid;
  logic [IDX_W-1:0]      issue_index;
  logic                  issue_ready;
  logic                  free_en;
  logic [IDX_W-1:0]      free_index;

  modport master (
    output flush, alloc_en, alloc_index, request_vector, issue_ready,
    input  grant_en, grant_index, issue_valid, issue_index, free_en, free_index
  );

  modport slave (
    input  flush, alloc_en, alloc_index, request_vector, issue_ready,
    output grant_en, grant_index, issue_valid, issue_index, free_en, free_index
  );
endinterface

// File: rtl/rs_issue_select_age_matrix.sv
// Age matrix for oldest-first select: age[i][j]=1 means entry i is older than entry j.
// Produces a one-hot pick of the oldest requester; unresolved ties fall to the lowest index.
module rs_age_matrix #(
  parameter int RS_ENTRIES = rs_issue_select_pkg::RS_ENTRIES,
  localparam int IDX_W     = $clog2(RS_ENTRIES)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  alloc_en,
  input  logic [IDX_W-1:0]      alloc_index,
  input  logic [RS_ENTRIES-1:0] req,
  output logic [RS_ENTRIES-1:0] pick_oh
);
  logic [RS_ENTRIES-1:0] age [RS_ENTRIES];
  logic [RS_ENTRIES-1:0] cand;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int i = 0; i < RS_ENTRIES; i++) age[i] <= '0;
    end else if (alloc_en) begin
      // New entry becomes the youngest: nobody is younger than it, everybody is older.
      for (int i = 0; i < RS_ENTRIES; i++) begin
        if (IDX_W'(i) == alloc_index) age[i] <= '0;
        else                          age[i][alloc_index] <= 1'b1;
      end
    end
  end

  always_comb begin
    cand = '0;
    for (int i = 0; i < RS_ENTRIES; i++) begin
      logic older_req;
      older_req = 1'b0;
      for (int j = 0; j < RS_ENTRIES; j++) older_req = older_req | (req[j] & age[j][i]);
      cand[i] = req[i] & ~older_req;
    end
  end

  assign pick_oh = cand & (~cand + RS_ENTRIES'(1));
endmodule

// File: rtl/rs_issue_select.sv
// RS issue select: one grant per cycle into a valid/ready issue register, free on handshake.
// Define SELECT_AGE_PRIORITY_EN for oldest-first select; default build is round-robin.
module rs_issue_select
  import rs_issue_select_pkg::*;
#(
  parameter int RS_ENTRIES = rs_issue_select_pkg::RS_ENTRIES,
  localparam int IDX_W     = $clog2(RS_ENTRIES)
) (
  input logic                clk,
  input logic                rst,
  rs_issue_select_if.slave   io
);
  logic                  accept;
  logic                  grant;
  logic [RS_ENTRIES-1:0] pick_oh;
  logic [IDX_W-1:0]      pick_idx;
  logic                  issue_valid_q;
  logic [IDX_W-1:0]      issue_index_q;
  logic                  alloc_conflict;

`ifdef SELECT_AGE_PRIORITY_EN
  rs_age_matrix #(.RS_ENTRIES(RS_ENTRIES)) u_age (
    .clk         (clk),
    .rst         (rst),
    .flush       (io.flush),
    .alloc_en    (io.alloc_en),
    .alloc_index (io.alloc_index),
    .req         (io.request_vector),
    .pick_oh     (pick_oh)
  );
`else
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] rr_idx;
  logic             rr_found;

  always_comb begin
    pick_oh  = '0;
    rr_idx   = '0;
    rr_found = 1'b0;
    for (int off = 0; off < RS_ENTRIES; off++) begin
      rr_idx = IDX_W'((int'(rr_ptr) + off) % RS_ENTRIES);
      if (!rr_found && io.request_vector[rr_idx]) begin
        pick_oh[rr_idx] = 1'b1;
        rr_found        = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || io.flush)             rr_ptr <= '0;
    else if (grant) begin
      if (pick_idx == IDX_W'(RS_ENTRIES - 1)) rr_ptr <= '0;
      else                                    rr_ptr <= pick_idx + IDX_W'(1);
    end
  end
`endif

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < RS_ENTRIES; i++)
      if (pick_oh[i]) pick_idx = pick_idx | IDX_W'(i);
  end

  assign accept = ~issue_valid_q | io.issue_ready;
  assign grant  = accept & (|io.request_vector) & ~io.flush & ~rst;

  always_ff @(posedge clk) begin
    if (rst || io.flush) begin
      issue_valid_q <= 1'b0;
      issue_index_q <= '0;
    end else if (grant) begin
      issue_valid_q <= 1'b1;
      issue_index_q <= pick_idx;
    end else if (accept) begin
      issue_valid_q <= 1'b0;
    end
  end

  assign io.grant_en    = grant;
  assign io.grant_index = grant ? pick_idx : '0;
  assign io.issue_valid = issue_valid_q;
  assign io.issue_index = issue_index_q;
  assign io.free_en     = issue_valid_q & io.issue_ready & ~io.flush & ~rst;
  assign io.free_index  = issue_index_q;

  // An entry cannot be ready to issue in the cycle dispatch is still writing it.
  assign alloc_conflict = io.alloc_en & io.request_vector[io.alloc_index];
  a_no_req_on_alloc: assert property (@(posedge clk) disable iff (rst) !alloc_conflict);
endmodule
